alu_op_scheduler: RTL

//   Shares one small reduction/pass-through ALU datapath between NUM_REQ requesters.
//   - Each requester presents an opcode and operand on a valid/ready port.
//   - A round-robin arbiter grants at most one request per cycle.
//   - A 2-stage pipeline computes the result, returned on one valid/ready response port

---
 rtl/alu_sched_pkg.sv | 8 +
 rtl/alu_op_unit.sv | 21 ++
 rtl/alu_op_scheduler.sv | 96 +++++++++
 3 files changed

// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: opcode encoding and result-width helper shared by the ALU scheduler.
package alu_sched_pkg;
    localparam int OP_W = 2;
    typedef enum logic [OP_W-1:0] {OP_HI_NOR, OP_HI_OR, OP_LO_NOR, OP_XOR} alu_op_e;
    function automatic int res_w(input int data_w);
        return data_w / 2 + 1;
    endfunction
endpackage

// File: rtl/alu_op_unit.sv
// alu_op_unit: combinational reduction/pass-through op producing {flag, half}.
module alu_op_unit
    import alu_sched_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  alu_op_e                    op_i,
    input  logic [DATA_W-1:0]          data_i,
    output logic [res_w(DATA_W)-1:0]   res_o
);
    localparam int HALF_W = DATA_W / 2;
    logic [HALF_W-1:0] hi, lo;
    assign hi = data_i[DATA_W-1:HALF_W];
    assign lo = data_i[HALF_W-1:0];
    always_comb begin
        res_o = op_i == OP_HI_NOR ? {~|hi, hi} :
                op_i == OP_HI_OR  ? {|hi, hi}  :
                op_i == OP_LO_NOR ? {~|lo, lo} :
                                    {^data_i, hi ^ lo};
    end
endmodule

// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: round-robin arbitration of NUM_REQ requesters onto a shared
// ALU with an S1 operand stage and an OUT result stage behind valid/ready.
module alu_op_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*OP_W-1:0]      req_op,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [DATA_W/2:0]            rsp_data
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int RES_W = res_w(DATA_W);

    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d, s1_id_q, s1_id_d, rsp_id_q, rsp_id_d, gnt, idx;
    logic              s1_valid_q, s1_valid_d, rsp_valid_q, rsp_valid_d;
    logic              found, out_free, s1_free, xfer, load;
    alu_op_e           s1_op_q, s1_op_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic [RES_W-1:0]  res, rsp_data_q, rsp_data_d;

    assign out_free = !rsp_valid_q || rsp_ready;
    assign s1_free  = !s1_valid_q || out_free;
    assign xfer     = found && s1_free;
    assign load     = out_free && s1_valid_q;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    always_comb begin
        req_ready      = '0;
        req_ready[gnt] = xfer;
    end

    always_comb begin
        rr_ptr_d    = xfer ? ID_W'((int'(gnt) + 1) % NUM_REQ) : rr_ptr_q;
        s1_valid_d  = s1_free ? xfer : s1_valid_q;
        s1_op_d     = xfer ? alu_op_e'(req_op[int'(gnt)*OP_W +: OP_W]) : s1_op_q;
        s1_data_d   = xfer ? req_data[int'(gnt)*DATA_W +: DATA_W] : s1_data_q;
        s1_id_d     = xfer ? gnt : s1_id_q;
        rsp_valid_d = out_free ? s1_valid_q : rsp_valid_q;
        rsp_id_d    = load ? s1_id_q : rsp_id_q;
        rsp_data_d  = load ? res : rsp_data_q;
    end

    alu_op_unit #(.DATA_W(DATA_W)) u_alu (
        .op_i   (s1_op_q),
        .data_i (s1_data_q),
        .res_o  (res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_HI_NOR;
            s1_data_q   <= '0;
            s1_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_data_q   <= s1_data_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
endmodule
